// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver with 16x oversampling. It samples each data bit
//                and the stop bit at mid-bit, and reports a good frame or a
//                framing error with a one-cycle pulse.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DBIT        data bits per frame (at least 2)
//    BAUD_DIV    i_clk cycles per oversampling tick
//    OVS         oversampling ticks per bit (even, at least 2)
//  Ports
//    i_clk       clock; all state changes on its rising edge
//    i_reset     asynchronous active-low reset
//    i_rx        serial line, idle high, asynchronous to i_clk
//    o_data      last correctly framed word, LSB received first
//    o_rx_done   one-cycle pulse when o_data is updated
//    o_frame_err one-cycle pulse when the stop bit is sampled low
//    o_busy      high while a frame is in progress (FSM not in IDLE)
// ============================================================================
module uart_rx #(
   parameter int DBIT     = 8,
   parameter int BAUD_DIV = 163,
   parameter int OVS      = 16
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_rx,
   output logic [DBIT-1:0] o_data,
   output logic            o_rx_done,
   output logic            o_frame_err,
   output logic            o_busy
);

   localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int SW = (OVS > 1)      ? $clog2(OVS)      : 1;
   localparam int NW = (DBIT > 1)     ? $clog2(DBIT)     : 1;

   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [SW-1:0] S_MID     = SW'(OVS / 2 - 1);
   localparam logic [SW-1:0] S_LAST    = SW'(OVS - 1);
   localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // ------------------------------------------------------------------------
   // Input synchronizer and falling-edge detection
   // ------------------------------------------------------------------------
   logic       rx_meta;
   logic       rx_s;
   logic       rx_prev;
   logic [1:0] sync_ok;
   logic       rx_fall;

   // sync_ok[1] marks the point after reset where rx_s first reflects the
   // real line instead of the flops' reset value. Until then rx_prev stays 0,
   // so a line that is already low when reset is released does not look like
   // a start edge. Reception waits for the line to go high and then fall.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b0;
         sync_ok <= 2'b00;
      end else begin
         rx_meta <= i_rx;
         rx_s    <= rx_meta;
         sync_ok <= {sync_ok[0], 1'b1};
         rx_prev <= sync_ok[1] ? rx_s : 1'b0;
      end
   end

   assign rx_fall = rx_prev & ~rx_s;

   // ------------------------------------------------------------------------
   // Free-running oversampling tick generator. It is not realigned to the
   // start edge, so the sample points can jitter by up to one tick.
   // ------------------------------------------------------------------------
   logic [BW-1:0] baud_cnt;
   logic          tick;

   assign tick = (baud_cnt == BAUD_LAST);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         baud_cnt <= '0;
      end else if (tick) begin
         baud_cnt <= '0;
      end else begin
         baud_cnt <= baud_cnt + BW'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Receive FSM
   // ------------------------------------------------------------------------
   state_t          state, state_next;
   logic [SW-1:0]   s, s_next;
   logic [NW-1:0]   n, n_next;
   logic [DBIT-1:0] b, b_next;
   logic [DBIT-1:0] data_next;
   logic            done_next;
   logic            err_next;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state       <= IDLE;
         s           <= '0;
         n           <= '0;
         b           <= '0;
         o_data      <= '0;
         o_rx_done   <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         state       <= state_next;
         s           <= s_next;
         n           <= n_next;
         b           <= b_next;
         o_data      <= data_next;
         o_rx_done   <= done_next;
         o_frame_err <= err_next;
      end
   end

   always_comb begin
      state_next = state;
      s_next     = s;
      n_next     = n;
      b_next     = b;
      data_next  = o_data;
      done_next  = 1'b0;
      err_next   = 1'b0;

      case (state)
         IDLE: begin
            if (rx_fall) begin
               state_next = START;
               s_next     = '0;
            end
         end

         // Check the start bit again at its midpoint. A line that is already
         // back high is treated as a glitch.
         START: begin
            if (tick) begin
               if (s == S_MID) begin
                  if (!rx_s) begin
                     state_next = DATA;
                     s_next     = '0;
                     n_next     = '0;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  s_next = s + SW'(1);
               end
            end
         end

         // From here on s == OVS-1 falls at the middle of each bit.
         DATA: begin
            if (tick) begin
               if (s == S_LAST) begin
                  s_next = '0;
                  b_next = {rx_s, b[DBIT-1:1]};
                  if (n == N_LAST) begin
                     state_next = STOP;
                  end else begin
                     n_next = n + NW'(1);
                  end
               end else begin
                  s_next = s + SW'(1);
               end
            end
         end

         // Leave at mid stop bit. The remaining half bit gives the receiver
         // room to catch the next start edge of a back-to-back frame.
         STOP: begin
            if (tick) begin
               if (s == S_LAST) begin
                  state_next = IDLE;
                  s_next     = '0;
                  if (rx_s) begin
                     data_next = b;
                     done_next = 1'b1;
                  end else begin
                     err_next  = 1'b1;
                  end
               end else begin
                  s_next = s + SW'(1);
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign o_busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking directed testbench for uart_rx
//                (BAUD_DIV=4, OVS=16, so one bit lasts 64 clocks).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

   localparam int DBIT     = 8;
   localparam int BAUD_DIV = 4;
   localparam int OVS      = 16;
   localparam int BIT_CLKS = BAUD_DIV * OVS;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            rx;
   logic [DBIT-1:0] data;
   logic            rx_done;
   logic            frame_err;
   logic            busy;

   uart_rx #(
      .DBIT     (DBIT),
      .BAUD_DIV (BAUD_DIV),
      .OVS      (OVS)
   ) dut (
      .i_clk       (clk),
      .i_reset     (rst_n),
      .i_rx        (rx),
      .o_data      (data),
      .o_rx_done   (rx_done),
      .o_frame_err (frame_err),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Cycle counter and output monitor, sampled on the falling edge
   int             cyc = 0;
   int             done_cnt = 0;
   int             err_cnt = 0;
   int             both_cnt = 0;
   int             wide_cnt = 0;
   int             data_glitch = 0;
   int             busy_at_done = 0;
   int             last_done_cyc = 0;
   int             start_cyc = 0;
   logic           done_prev = 1'b0;
   logic           err_prev = 1'b0;
   logic [DBIT-1:0] prev_data = '0;
   logic [DBIT-1:0] rx_q[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rx_done) begin
         done_cnt++;
         rx_q.push_back(data);
         last_done_cyc = cyc;
         if (busy) busy_at_done++;
      end
      if (frame_err) err_cnt++;
      if (rx_done && frame_err) both_cnt++;
      if ((rx_done && done_prev) || (frame_err && err_prev)) wide_cnt++;
      if (rst_n && !rx_done && (data !== prev_data)) data_glitch++;
      prev_data = data;
      done_prev = rx_done;
      err_prev  = frame_err;
   end

   task automatic send_bit(input logic v);
      rx = v;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_v);
      start_cyc = cyc;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop_v);
      rx = 1'b1;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++;
      if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data); end
      n_checks++;
      if (rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", rx_done); end
      n_checks++;
      if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", frame_err); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_single();
      int d0, e0, lat;
      d0 = done_cnt;
      e0 = err_cnt;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_before: got %b want 0", busy); end
      fork
         send_frame(8'hA5, 1'b1);
         begin
            repeat (BIT_CLKS * 3) @(negedge clk);
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_mid: got %b want 1", busy); end
         end
      join
      repeat (10) @(negedge clk);
      n_checks++;
      if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", done_cnt - d0); end
      n_checks++;
      if (data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", data); end
      n_checks++;
      if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL single_err_count: got %0d want 0", err_cnt - e0); end
      lat = last_done_cyc - start_cyc;
      n_checks++;
      if (lat < 590 || lat > 630) begin n_fail++; $display("FAIL single_latency: got %0d clocks want 590..630", lat); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_back_to_back();
      int          d0, e0;
      logic [7:0]  exp_v[3];
      logic [7:0]  got;
      exp_v[0] = 8'h3C;
      exp_v[1] = 8'hFF;
      exp_v[2] = 8'h00;
      d0 = done_cnt;
      e0 = err_cnt;
      rx_q.delete();
      send_frame(8'h3C, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h00, 1'b1);
      repeat (20) @(negedge clk);
      n_checks++;
      if (done_cnt - d0 !== 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 3", done_cnt - d0); end
      n_checks++;
      if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL b2b_err_count: got %0d want 0", err_cnt - e0); end
      for (int i = 0; i < 3; i++) begin
         got = (rx_q.size() > i) ? rx_q[i] : 8'hxx;
         n_checks++;
         if (got !== exp_v[i]) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", i, got, exp_v[i]); end
      end
      n_checks++;
      if (data !== 8'h00) begin n_fail++; $display("FAIL b2b_final_data: got %h want 00", data); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_glitch();
      int d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      rx = 1'b0;
      repeat (10) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
      rx = 1'b1;
      repeat (100) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_after: got %b want 0", busy); end
      n_checks++;
      if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL glitch_done_count: got %0d want 0", done_cnt - d0); end
      n_checks++;
      if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL glitch_err_count: got %0d want 0", err_cnt - e0); end
      n_checks++;
      if (data !== 8'h00) begin n_fail++; $display("FAIL glitch_data: got %h want 00", data); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_frame_err();
      int d0, e0;
      send_frame(8'hA5, 1'b1);
      repeat (10) @(negedge clk);
      d0 = done_cnt;
      e0 = err_cnt;
      send_frame(8'h55, 1'b0);
      repeat (BIT_CLKS) @(negedge clk);
      n_checks++;
      if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL ferr_err_count: got %0d want 1", err_cnt - e0); end
      n_checks++;
      if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL ferr_done_count: got %0d want 0", done_cnt - d0); end
      n_checks++;
      if (data !== 8'hA5) begin n_fail++; $display("FAIL ferr_data: got %h want a5", data); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy: got %b want 0", busy); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset_abort();
      int d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      fork
         send_frame(8'h81, 1'b1);
         begin
            // middle of data bit 4 (start + bits 0..3 + half a bit)
            repeat (BIT_CLKS * 5 + BIT_CLKS / 2) @(negedge clk);
            rst_n = 1'b0;
            repeat (3) @(negedge clk);
            n_checks++;
            if (data !== 8'h00) begin n_fail++; $display("FAIL abort_data_in_reset: got %h want 00", data); end
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_in_reset: got %b want 0", busy); end
            rst_n = 1'b1;
         end
      join
      repeat (100) @(negedge clk);
      n_checks++;
      if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL abort_done_count: got %0d want 0", done_cnt - d0); end
      n_checks++;
      if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL abort_err_count: got %0d want 0", err_cnt - e0); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy_idle: got %b want 0", busy); end
      n_checks++;
      if (data !== 8'h00) begin n_fail++; $display("FAIL abort_data_after: got %h want 00", data); end
      send_frame(8'h42, 1'b1);
      repeat (20) @(negedge clk);
      n_checks++;
      if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL abort_next_done_count: got %0d want 1", done_cnt - d0); end
      n_checks++;
      if (data !== 8'h42) begin n_fail++; $display("FAIL abort_next_data: got %h want 42", data); end
      n_checks++;
      if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL abort_next_err_count: got %0d want 0", err_cnt - e0); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_global();
      n_checks++;
      if (both_cnt !== 0) begin n_fail++; $display("FAIL done_and_err_together: got %0d want 0", both_cnt); end
      n_checks++;
      if (wide_cnt !== 0) begin n_fail++; $display("FAIL pulse_width: got %0d wide pulses want 0", wide_cnt); end
      n_checks++;
      if (data_glitch !== 0) begin n_fail++; $display("FAIL data_stable: got %0d stray changes want 0", data_glitch); end
      n_checks++;
      if (busy_at_done !== 0) begin n_fail++; $display("FAIL busy_at_done: got %0d want 0", busy_at_done); end
   endtask

   initial begin
      rst_n = 1'b0;
      rx    = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_abort();
      test_global();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DBIT, default 8, number of data bits per frame.
REQ-002 Parameter BAUD_DIV, default 163, i_clk cycles per oversampling tick (50 MHz / (19200 x 16)).
REQ-003 Parameter OVS, default 16, oversampling ticks per bit.
REQ-004 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-low reset.
REQ-006 i_rx  input  1  serial line; idle high; asynchronous to i_clk.
REQ-007 o_data  output  DBIT  last correctly framed byte, LSB received first.
REQ-008 o_rx_done  output  1  one-cycle pulse when o_data is updated; feeds the interface block's i_rx_done.
REQ-009 o_frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 o_busy  output  1  high in any state other than IDLE.

Function
REQ-011 i_rx shall pass through a 2-flop synchronizer whose flops reset to 1; all logic uses the synchronized value (rx_s).
REQ-012 A free-running counter shall count 0..BAUD_DIV-1 and wrap; tick is high for the one cycle where count = BAUD_DIV-1.
REQ-013 The FSM shall have states IDLE, START, DATA, STOP, with tick counter s (0..OVS-1), bit counter n (0..DBIT-1) and shift register b (DBIT bits).
REQ-014 IDLE: when rx_s = 0, go to START and clear s; the tick counter is not realigned.
REQ-015 START: on each tick, if s = OVS/2-1, then rx_s = 0 -> DATA with s=0, n=0; rx_s = 1 -> IDLE (glitch rejected, no outputs asserted); otherwise s increments.
REQ-016 DATA: on each tick, if s = OVS-1, then s=0, b = {rx_s, b[DBIT-1:1]}; if n = DBIT-1 -> STOP, else n increments; otherwise s increments.
REQ-017 STOP: on the tick where s = OVS-1 (mid stop bit), go to IDLE; rx_s = 1 -> o_data <= b and o_rx_done pulses; rx_s = 0 -> o_frame_err pulses and o_data keeps its old value.
REQ-018 o_rx_done and o_frame_err shall be registered, high exactly one i_clk cycle, never both high in the same cycle.
REQ-019 o_data shall change only in the cycle o_rx_done rises and shall hold until the next good frame.
REQ-020 A line held low through STOP shall not retrigger until rx_s returns high, then falls again (IDLE requires a 1->0 transition; track rx_s previous value).
REQ-021 Frames arriving back-to-back with a single stop bit shall all be received without loss.
REQ-022 Line activity in non-IDLE states other than at sample points shall be ignored.

Reset
REQ-023 While i_reset = 0: state=IDLE, s=0, n=0, b=0, baud counter=0, synchronizer flops=1, o_data=0, o_rx_done=0, o_frame_err=0, o_busy=0.
REQ-024 Reset asserted mid-frame shall abort the frame immediately with no o_rx_done or o_frame_err pulse; after release, reception restarts only on a new falling edge.

Verification (BAUD_DIV=4, OVS=16 -> 64 clocks/bit)
REQ-025 Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> one o_rx_done pulse about 9.5 bit times after the start edge, o_data=0xA5, o_frame_err never high.
REQ-026 Send 0x3C, then 0xFF, then 0x00 back-to-back with one stop bit each -> three o_rx_done pulses, o_data sequence 0x3C, 0xFF, 0x00.
REQ-027 Drive a 10-clock low glitch on idle i_rx -> returns to IDLE, no pulse on o_rx_done or o_frame_err, o_data unchanged.
REQ-028 Send 0x55 with stop bit driven 0 -> o_frame_err pulses once, o_rx_done stays 0, o_data retains its previous value 0xA5.
REQ-029 Assert i_reset during data bit 4 of 0x81, release, then send 0x42 -> no pulse for the aborted frame; o_data=0 after reset, then 0x42 with one o_rx_done.
REQ-030 Across all tests, o_busy shall be high from the start edge to the STOP sample and low otherwise.
